sdram_stream_arbiter: RTL and testbench

- Sits directly upstream of the SDRAM controller and drives its pseudo-dual-port interface: waddr/wdata/we/raddr/rdata plus the rdy/ack handshake.
- Buffers the acquisition sample stream in a small FIFO and writes it to SDRAM as a circular buffer.
- Serves host block-read requests (start address, length) by streaming SDRAM words out.
- Arbitrates between writes and reads, and enforces the controller's mandatory rdy-low cycle between directions.

---
 rtl/sdram_stream_arbiter_pkg.sv | 18 +
 rtl/sdram_arb_defs.vh | 15 +
 rtl/sdram_stream_arbiter_sync_fifo.sv | 59 +++++
 rtl/sdram_stream_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sdram_stream_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_stream_arbiter_pkg.sv
// Types and default constants for the SDRAM stream arbiter, built from the shared defines.
`include "sdram_arb_defs.vh"

package sdram_stream_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = `ARB_ST_IDLE,
    ST_WRITE = `ARB_ST_WRITE,
    ST_READ  = `ARB_ST_READ
  } arb_state_t;

  localparam int DEF_DATA_WIDTH = `ARB_DATA_WIDTH;
  localparam int DEF_ADDR_WIDTH = `ARB_ADDR_WIDTH;
  localparam int DEF_FIFO_DEPTH = `ARB_FIFO_DEPTH;
  localparam int DEF_WR_THRESH  = `ARB_WR_THRESH;
  localparam int DEF_MAX_BURST  = `ARB_MAX_BURST;

endpackage

// File: rtl/sdram_arb_defs.vh
// Shared FSM state encodings and default parameter values for the SDRAM stream arbiter.
`ifndef SDRAM_ARB_DEFS_VH
`define SDRAM_ARB_DEFS_VH

`define ARB_ST_IDLE      2'd0
`define ARB_ST_WRITE     2'd1
`define ARB_ST_READ      2'd2

`define ARB_DATA_WIDTH   16
`define ARB_ADDR_WIDTH   20
`define ARB_FIFO_DEPTH   16
`define ARB_WR_THRESH    8
`define ARB_MAX_BURST    64

`endif

// File: rtl/sdram_stream_arbiter_sync_fifo.sv
// First-word-fall-through FIFO with occupancy count and synchronous flush.
// Full is a registered flag, so a push into a full FIFO is refused even if it is popped that cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [DATA_WIDTH-1:0]      i_data,
  input  logic                       i_pop,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_idx;
  logic [AW-1:0]         r_rd_idx;
  logic [AW:0]           r_count;
  logic                  w_push;
  logic                  w_pop;

  assign w_push  = i_push & ~r_count[AW];
  assign w_pop   = i_pop & (r_count != '0);
  assign o_data  = r_mem[r_rd_idx];
  assign o_count = r_count;
  assign o_full  = r_count[AW];
  assign o_empty = (r_count == '0);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_idx <= r_wr_idx + 1'b1;
      if (w_pop)  r_rd_idx <= r_rd_idx + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !i_flush) r_mem[r_wr_idx] <= i_data;
  end

endmodule

// File: rtl/sdram_stream_arbiter.sv
// Arbitrates a buffered sample stream (circular SDRAM writes) against host block reads,
// inserting an sd_rdy-low IDLE cycle between every pair of bursts.
module sdram_stream_arbiter
  import sdram_stream_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int WR_THRESH  = DEF_WR_THRESH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ready,
  input  logic                  wr_clr,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic                  overflow,
  input  logic                  rd_start,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH-1:0] rd_len,
  output logic                  rd_busy,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic [ADDR_WIDTH-1:0] sd_waddr,
  output logic [DATA_WIDTH-1:0] sd_wdata,
  output logic                  sd_we,
  output logic [ADDR_WIDTH-1:0] sd_raddr,
  input  logic [DATA_WIDTH-1:0] sd_rdata,
  output logic                  sd_rdy,
  input  logic                  sd_ack
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(MAX_BURST) + 1;

  arb_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_rem;
  logic [BW-1:0]         r_burst_cnt;
  logic                  r_overflow;
  logic                  r_rd_busy;
  logic                  r_rd_valid;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_sd_rdy;
  logic                  r_sd_we;

  logic [DATA_WIDTH-1:0] w_fifo_data;
  logic [CW:0]           w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ack;
  logic                  w_thresh;
  logic                  w_wr_last;
  logic                  w_burst_end;
  logic                  w_rd_accept;

  assign w_ack       = r_sd_rdy & sd_ack;
  assign w_push      = wr_valid & ~w_fifo_full & ~wr_clr;
  assign w_pop       = (r_state == ST_WRITE) & w_ack & ~wr_clr;
  assign w_thresh    = (w_fifo_count >= (CW+1)'(WR_THRESH));
  assign w_wr_last   = (w_fifo_count == (CW+1)'(1)) & ~w_push;
  assign w_burst_end = r_rd_busy & (r_burst_cnt == BW'(MAX_BURST - 1));
  assign w_rd_accept = rd_start & ~r_rd_busy & (rd_len != '0);

  sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst     (rst),
    .i_flush (wr_clr),
    .i_push  (w_push),
    .i_data  (wr_data),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rd_rem    <= '0;
      r_burst_cnt <= '0;
      r_overflow  <= 1'b0;
      r_rd_busy   <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_sd_rdy    <= 1'b0;
      r_sd_we     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;

      if (wr_clr) begin
        r_wr_ptr   <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_pop) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (wr_valid && w_fifo_full) r_overflow <= 1'b1;
      end

      if (w_rd_accept) begin
        r_rd_ptr  <= rd_addr;
        r_rd_rem  <= rd_len;
        r_rd_busy <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_sd_rdy    <= 1'b0;
          r_burst_cnt <= '0;
          if (w_thresh && !wr_clr) begin
            r_state  <= ST_WRITE;
            r_sd_we  <= 1'b1;
            r_sd_rdy <= 1'b1;
          end else if (r_rd_busy) begin
            r_state  <= ST_READ;
            r_sd_we  <= 1'b0;
            r_sd_rdy <= 1'b1;
          end else if (!w_fifo_empty && !wr_clr) begin
            r_state  <= ST_WRITE;
            r_sd_we  <= 1'b1;
            r_sd_rdy <= 1'b1;
          end
        end
        ST_WRITE: begin
          // A flush discards any ack arriving in the same cycle.
          if (wr_clr) begin
            r_sd_rdy <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (w_ack) begin
            r_burst_cnt <= r_burst_cnt + 1'b1;
            if (w_wr_last || w_burst_end) begin
              r_sd_rdy <= 1'b0;
              r_state  <= ST_IDLE;
            end
          end
        end
        ST_READ: begin
          if (w_ack) begin
            r_rd_data  <= sd_rdata;
            r_rd_valid <= 1'b1;
            r_rd_ptr   <= r_rd_ptr + 1'b1;
            r_rd_rem   <= r_rd_rem - 1'b1;
          end
          if (w_ack && (r_rd_rem == ADDR_WIDTH'(1))) begin
            r_rd_busy <= 1'b0;
            r_sd_rdy  <= 1'b0;
            r_state   <= ST_IDLE;
          end else if (w_thresh) begin
            r_sd_rdy <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_sd_rdy <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr_ready   = ~w_fifo_full;
  assign wr_ptr     = r_wr_ptr;
  assign overflow   = r_overflow;
  assign rd_busy    = r_rd_busy;
  assign rd_data_o  = r_rd_data;
  assign rd_valid_o = r_rd_valid;
  assign sd_waddr   = r_wr_ptr;
  assign sd_wdata   = (r_state == ST_WRITE) ? w_fifo_data : '0;
  assign sd_we      = r_sd_we;
  assign sd_raddr   = r_rd_ptr;
  assign sd_rdy     = r_sd_rdy;

endmodule

// File: tb/tb_sdram_stream_arbiter.sv
// Scoreboard bench for sdram_stream_arbiter: directed stimulus queues expected SDRAM
// transfers and read words; a negedge monitor pops and compares them.
module tb_sdram_stream_arbiter;
  import sdram_stream_arbiter_pkg::*;

  localparam int DW = DEF_DATA_WIDTH;
  localparam int AW = DEF_ADDR_WIDTH;

  logic          clk_i = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          wr_clr = 1'b0;
  logic [AW-1:0] wr_ptr;
  logic          overflow;
  logic          rd_start = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [AW-1:0] rd_len = '0;
  logic          rd_busy;
  logic [DW-1:0] rd_data_o;
  logic          rd_valid_o;
  logic [AW-1:0] sd_waddr;
  logic [DW-1:0] sd_wdata;
  logic          sd_we;
  logic [AW-1:0] sd_raddr;
  logic [DW-1:0] sd_rdata;
  logic          sd_rdy;
  logic          sd_ack = 1'b0;

  sdram_stream_arbiter dut (
    .clk_i(clk_i), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .wr_clr(wr_clr), .wr_ptr(wr_ptr), .overflow(overflow), .rd_start(rd_start),
    .rd_addr(rd_addr), .rd_len(rd_len), .rd_busy(rd_busy), .rd_data_o(rd_data_o),
    .rd_valid_o(rd_valid_o), .sd_waddr(sd_waddr), .sd_wdata(sd_wdata), .sd_we(sd_we),
    .sd_raddr(sd_raddr), .sd_rdata(sd_rdata), .sd_rdy(sd_rdy), .sd_ack(sd_ack)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  assign sd_rdata = mem_word(sd_raddr);

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_wr_q[$];
  logic [AW-1:0] exp_ra_q[$];
  logic [DW-1:0] exp_rd_q[$];
  logic [AW-1:0] exp_wptr = '0;
  int checks = 0;
  int errors = 0;
  int wr_xfers = 0;
  int rd_strobes = 0;
  int low_run = 0;
  int last_gap = -1;
  logic prev_rdy = 1'b0;
  logic prev_we = 1'b0;
  logic last_read = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every SDRAM transfer and every read strobe against the queues.
  always @(negedge clk_i) begin
    if (rst) begin
      prev_rdy = 1'b0;
      low_run  = 0;
    end else begin
      if (rd_valid_o) begin
        rd_strobes++;
        if (exp_rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd_strobe: got data 0x%0h expected none", rd_data_o);
        end else begin
          chk("rd_data", rd_data_o, exp_rd_q.pop_front());
          chk("rd_busy_at_strobe", rd_busy, (exp_ra_q.size() != 0));
        end
      end
      if (sd_rdy && !prev_rdy && sd_we && last_read) last_gap = low_run;
      if (sd_rdy && prev_rdy) chk("dir_stable", sd_we, prev_we);
      if (sd_rdy && sd_ack && !(sd_we && wr_clr)) begin
        if (sd_we) begin
          wr_xfers++;
          last_read = 1'b0;
          if (exp_wr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", sd_waddr, sd_wdata);
          end else begin
            wr_t e;
            e = exp_wr_q.pop_front();
            chk("sd_waddr", sd_waddr, e.a);
            chk("sd_wdata", sd_wdata, e.d);
          end
        end else begin
          last_read = 1'b1;
          if (exp_ra_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_read: got addr 0x%0h expected none", sd_raddr);
          end else begin
            logic [AW-1:0] ea;
            ea = exp_ra_q.pop_front();
            chk("sd_raddr", sd_raddr, ea);
            exp_rd_q.push_back(mem_word(ea));
          end
        end
      end
      low_run  = sd_rdy ? 0 : low_run + 1;
      prev_rdy = sd_rdy;
      prev_we  = sd_we;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_burst(input logic [DW-1:0] base, input int n, input int n_acc);
    for (int i = 0; i < n; i++) begin
      wr_t e;
      wr_valid = 1'b1;
      wr_data  = base + DW'(i);
      if (i < n_acc) begin
        e.a = exp_wptr;
        e.d = wr_data;
        exp_wr_q.push_back(e);
        exp_wptr = exp_wptr + 1'b1;
      end
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic start_read(input logic [AW-1:0] a, input logic [AW-1:0] n, input bit expect_accept);
    rd_addr  = a;
    rd_len   = n;
    rd_start = 1'b1;
    if (expect_accept)
      for (int i = 0; i < int'(n); i++) exp_ra_q.push_back(a + AW'(i));
    tick();
    rd_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      done = (exp_wr_q.size() == 0) && (exp_ra_q.size() == 0) && (exp_rd_q.size() == 0)
             && !sd_rdy && !rd_busy;
    end
    chk({"idle_", nm}, done, 1'b1);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_sd_rdy"}, sd_rdy, 1'b0);
    chk({nm, "_sd_we"}, sd_we, 1'b0);
    chk({nm, "_sd_waddr"}, sd_waddr, '0);
    chk({nm, "_sd_raddr"}, sd_raddr, '0);
    chk({nm, "_sd_wdata"}, sd_wdata, '0);
    chk({nm, "_rd_busy"}, rd_busy, 1'b0);
    chk({nm, "_rd_valid"}, rd_valid_o, 1'b0);
    chk({nm, "_rd_data"}, rd_data_o, '0);
    chk({nm, "_overflow"}, overflow, 1'b0);
    chk({nm, "_wr_ptr"}, wr_ptr, '0);
    chk({nm, "_wr_ready"}, wr_ready, 1'b1);
  endtask

  initial begin
    int base;
    int seen;
    #1;
    chk_reset("por");
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Five samples written back to back with the controller always acking.
    sd_ack = 1'b1;
    push_burst(16'h0001, 5, 5);
    wait_idle("t1");
    chk("t1_wr_xfers", wr_xfers, 5);
    chk("t1_wr_ptr", wr_ptr, 20'd5);

    // Read wrapping the top of the address space; a second start while busy is ignored.
    start_read(20'hFFFFE, 20'd4, 1'b1);
    start_read(20'h00500, 20'd3, 1'b0);
    wait_idle("t2");
    chk("t2_rd_strobes", rd_strobes, 4);
    start_read(20'h00777, 20'd0, 1'b0);
    chk("t2_len0_busy", rd_busy, 1'b0);
    repeat (3) tick();
    chk("t2_len0_rdy", sd_rdy, 1'b0);

    // Write threshold pre-empts a streaming read, which then resumes where it stopped.
    last_gap = -1;
    start_read(20'h00100, 20'd16, 1'b1);
    repeat (3) tick();
    push_burst(16'h0010, 8, 8);
    wait_idle("t3");
    chk("t3_rd_to_wr_gap", last_gap, 1);
    chk("t3_rd_strobes", rd_strobes, 20);
    chk("t3_wr_xfers", wr_xfers, 13);
    chk("t3_wr_ptr", wr_ptr, 20'd13);

    // Controller stalled: sixteen samples fit, the seventeenth overflows.
    sd_ack = 1'b0;
    push_burst(16'h0200, 17, 16);
    chk("t4_wr_ready_full", wr_ready, 1'b0);
    chk("t4_overflow_set", overflow, 1'b1);
    sd_ack = 1'b1;
    wait_idle("t4");
    chk("t4_wr_xfers", wr_xfers, 29);
    chk("t4_wr_ptr", wr_ptr, 20'd29);
    chk("t4_wr_ready_back", wr_ready, 1'b1);
    chk("t4_overflow_sticky", overflow, 1'b1);

    // Flush in the middle of a write burst, with an ack arriving in the same cycle.
    sd_ack = 1'b0;
    push_burst(16'h0300, 6, 0);
    chk("t5_in_write", sd_rdy, 1'b1);
    wr_clr = 1'b1;
    sd_ack = 1'b1;
    tick();
    wr_clr = 1'b0;
    exp_wptr = '0;
    chk("t5_rdy_dropped", sd_rdy, 1'b0);
    chk("t5_wr_ptr", wr_ptr, '0);
    chk("t5_overflow", overflow, 1'b0);
    chk("t5_wr_ready", wr_ready, 1'b1);
    repeat (4) tick();
    chk("t5_fifo_empty", sd_rdy, 1'b0);
    chk("t5_wr_xfers", wr_xfers, 29);

    // Reset while a read has three words left.
    start_read(20'h00040, 20'd5, 1'b1);
    seen = 0;
    for (int i = 0; i < 20 && seen < 2; i++) begin
      tick();
      if (rd_valid_o) seen++;
    end
    sd_ack = 1'b0;
    chk("t6_two_words", seen, 2);
    repeat (2) tick();
    chk("t6_busy_before_rst", rd_busy, 1'b1);
    chk("t6_raddr_before_rst", sd_raddr, 20'h00042);
    rst = 1'b1;
    #1;
    chk_reset("t6");
    exp_ra_q.delete();
    exp_rd_q.delete();
    base = rd_strobes;
    repeat (2) tick();
    rst = 1'b0;
    sd_ack = 1'b1;
    repeat (8) tick();
    chk("t6_no_strobes", rd_strobes, base);
    chk("t6_busy_after", rd_busy, 1'b0);
    chk("t6_rdy_after", sd_rdy, 1'b0);
    chk("end_wr_queue", exp_wr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
